pakin_bfifo: RTL



---
 rtl/pakin_bfifo.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pakin_bfifo.sv
// pakin_bfifo -- receive side of a four-phase req/ack link.
// Accepts one packet per req pulse, checks its redundancy field, and queues
// good packets ({addr,data}) in a 2^FSZ-deep circular FIFO.
// Bad packets are still acknowledged but are dropped. They set a sticky error
// flag and bump a saturating 8-bit counter.
//
// Ports:
//   i_clk, reset         clock (rising edge), async active-high reset
//   rcv0_req/data/ack    link handshake; ack is registered
//   o_valid/o_ready      FIFO head handshake; pop on o_valid & o_ready
//   o_addr/o_data        FIFO head fields (combinational from head entry)
//   has_err, o_err_cnt   sticky error flag, saturating bad-packet count
//   dbg_busy             handshake in progress or FIFO non-empty
//
// state   | meaning
// ST_IDLE | ack low, waiting for req (held off while FIFO full)
// ST_ACK  | packet taken, ack high, waiting for req to drop
module pakin_bfifo #(
  parameter int PSZ = 12,
  parameter int ASZ = 4,
  parameter int DSZ = 4,
  parameter int RSZ = 4,
  parameter int FSZ = 2
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic           rcv0_req,
  input  logic [PSZ-1:0] rcv0_data,
  output logic           rcv0_ack,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [ASZ-1:0] o_addr,
  output logic [DSZ-1:0] o_data,
  output logic           has_err,
  output logic [7:0]     o_err_cnt,
  output logic           dbg_busy
);

  localparam int PLW   = ASZ + DSZ;
  localparam int DEPTH = 1 << FSZ;
  // Number of RSZ-wide slices covering the payload; top slice is zero-padded.
  localparam int NSL   = (PLW + RSZ - 1) / RSZ;

  localparam logic [FSZ:0]   FULL_CNT = {1'b1, {FSZ{1'b0}}};
  localparam logic [FSZ:0]   CNT_ONE  = 1;
  localparam logic [FSZ-1:0] PTR_ONE  = 1;

  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t         state_q, state_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic [FSZ-1:0] wr_ptr_q, wr_ptr_d;
  logic [FSZ-1:0] rd_ptr_q, rd_ptr_d;
  logic [FSZ:0]   count_q, count_d;
  logic [PLW-1:0] mem_q [DEPTH];

  logic [PLW-1:0]     payload;
  logic [NSL*RSZ-1:0] payload_pad;
  logic [RSZ-1:0]     redun_exp;
  logic               pkt_good;
  logic               full;
  logic               push;
  logic               pop;

  assign payload     = rcv0_data[PSZ-1:RSZ];
  assign payload_pad = (NSL*RSZ)'(payload);

  always_comb begin
    redun_exp = '0;
    for (int s = 0; s < NSL; s++) begin
      redun_exp = redun_exp ^ payload_pad[s*RSZ +: RSZ];
    end
  end

  assign pkt_good = (redun_exp == rcv0_data[RSZ-1:0]);
  assign full     = (count_q == FULL_CNT);
  assign o_valid  = (count_q != '0);
  assign pop      = o_valid & o_ready;

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Full is judged on the pre-pop count, so a same-cycle pop never
        // frees room for a push; the sender simply waits one more cycle.
        if (rcv0_req && !full) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (pkt_good) begin
            push = 1'b1;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      ST_ACK: begin
        if (!rcv0_req) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count says so.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= payload;
  end

  assign rcv0_ack  = ack_q;
  assign has_err   = err_q;
  assign o_err_cnt = err_cnt_q;
  assign {o_addr, o_data} = mem_q[rd_ptr_q];
  assign dbg_busy  = (state_q == ST_ACK) | (count_q != '0);

endmodule
